// File: rtl/inst_mem_responder_pkg.sv
// Shared constants and types for the instruction-memory responder:
// the NOP filler word, the wait-state LFSR definition and the response stage record.
package inst_mem_responder_pkg;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as a mask over bits [15:0].
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic        valid;
    logic        error;
    logic [31:0] data;
  } resp_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] state);
    return {state[14:0], ^(state & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/inst_mem_responder_if.sv
// Fetch-side bus between the core's PC/fetch logic (master) and the
// instruction memory (slave).
interface inst_mem_responder_if;

  logic        inst_mem_req;
  logic [31:0] inst_mem_address;
  logic        inst_mem_req_ready;
  logic        inst_mem_flush;
  logic        inst_mem_is_valid;
  logic [31:0] inst_mem_read_data;
  logic        inst_mem_error;

  modport master (
    output inst_mem_req, inst_mem_address, inst_mem_flush,
    input  inst_mem_req_ready, inst_mem_is_valid, inst_mem_read_data, inst_mem_error
  );

  modport slave (
    input  inst_mem_req, inst_mem_address, inst_mem_flush,
    output inst_mem_req_ready, inst_mem_is_valid, inst_mem_read_data, inst_mem_error
  );

endinterface

// File: rtl/inst_mem_resp_pipe.sv
// LATENCY-stage {valid, data, error} delay line with flush. Stage-1 data is the
// array's registered read port, owned by the top; this block owns everything else.
module inst_mem_resp_pipe
  import inst_mem_responder_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        acc_i,
  input  logic        err_i,
  input  logic [31:0] rd_data_i,
  output logic        valid_o,
  output logic        error_o,
  output logic [31:0] data_o
);

  logic s1_valid_q;
  logic s1_error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state updates use <= so every register samples pre-edge values, regardless of statement order.
      s1_valid_q <= 1'b0;
      s1_error_q <= 1'b0;
    end else begin
      // A request accepted on a flush edge survives: stage 1 is refilled, not cleared.
      s1_valid_q <= acc_i;
      if (acc_i) s1_error_q <= err_i;
    end
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign valid_o = s1_valid_q;
      assign error_o = s1_error_q;
      assign data_o  = rd_data_i;
    end else begin : g_tail
      resp_t tail_q [LATENCY-1];
      resp_t stage  [LATENCY];

      always_comb begin
        // NOTE: every element is assigned on every pass, so no latch is inferred.
        stage[0] = '{valid: s1_valid_q, error: s1_error_q, data: rd_data_i};
        for (int i = 1; i < LATENCY; i++) stage[i] = tail_q[i-1];
      end

      // Payload only moves with a surviving valid, so the output holds its last response.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LATENCY-1; i++) tail_q[i] <= '0;
        end else begin
          for (int i = 0; i < LATENCY-1; i++) begin
            tail_q[i].valid <= stage[i].valid && !flush_i;
            if (stage[i].valid && !flush_i) begin
              tail_q[i].data  <= stage[i].data;
              tail_q[i].error <= stage[i].error;
            end
          end
        end
      end

      assign valid_o = stage[LATENCY-1].valid;
      assign error_o = stage[LATENCY-1].error;
      assign data_o  = stage[LATENCY-1].data;
    end
  endgenerate

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-memory responder: preloadable synchronous-read word array with
// range/alignment checks feeding a fixed-latency response pipe.
// Optional random wait states: define INST_MEM_RANDOM_WAIT_EN.
module inst_mem_responder
  import inst_mem_responder_pkg::*;
#(
  parameter logic [31:0] RESET       = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  inst_mem_responder_if.slave            bus,
  input  logic                           init_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] init_addr,
  input  logic [31:0]                    init_data
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;

  logic [31:0] offset;
  logic        in_range;
  logic        misaligned;
  logic        legal;
  logic [AW-1:0] idx;
  logic        ready;
  logic        accept;
  logic [31:0] rd_data_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  // Wrapping subtraction makes addresses below RESET land far out of range.
  assign offset     = bus.inst_mem_address - RESET;
  assign in_range   = offset < SPAN;
  assign misaligned = |bus.inst_mem_address[1:0];
  assign legal      = in_range && !misaligned;
  assign idx        = offset[AW+1:2];

`ifdef INST_MEM_RANDOM_WAIT_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = lfsr_next(lfsr_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign ready = |lfsr_q[1:0];
`else
  assign ready = 1'b1;
`endif

  assign accept                 = bus.inst_mem_req && ready;
  assign bus.inst_mem_req_ready = ready;

  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; preload defines its contents.
    if (init_we) mem_q[init_addr] <= init_data;
  end

  // Reading here and writing above on the same edge returns the old word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else if (accept) begin
      if (legal) rd_data_q <= mem_q[idx];
      else       rd_data_q <= NOP;
    end
  end

  inst_mem_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (reset),
    .flush_i   (bus.inst_mem_flush),
    .acc_i     (accept),
    .err_i     (!legal),
    .rd_data_i (rd_data_q),
    .valid_o   (bus.inst_mem_is_valid),
    .error_o   (bus.inst_mem_error),
    .data_o    (bus.inst_mem_read_data)
  );

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench: three responders (LATENCY 1, 3, 4) share one stimulus stream and are
// scored against a queue-based response model plus scenario checks.
module tb_inst_mem_responder;

  localparam int          N      = 3;
  localparam int          DEPTH  = 256;
  localparam int          AW     = 8;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam logic [31:0] NOP_W  = 32'h0000_0013;
  localparam logic [31:0] WORD_A = 32'h1111_0001;
  localparam logic [31:0] WORD_B = 32'h2222_0002;
  localparam logic [31:0] WORD_C = 32'h3333_0003;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic          flush;
  logic [31:0]   addr;
  logic          init_we;
  logic [AW-1:0] init_addr;
  logic [31:0]   init_data;

  always #5 clk = ~clk;

  inst_mem_responder_if if_l1 ();
  inst_mem_responder_if if_l3 ();
  inst_mem_responder_if if_l4 ();

  assign if_l1.inst_mem_req = req;  assign if_l1.inst_mem_address = addr;  assign if_l1.inst_mem_flush = flush;
  assign if_l3.inst_mem_req = req;  assign if_l3.inst_mem_address = addr;  assign if_l3.inst_mem_flush = flush;
  assign if_l4.inst_mem_req = req;  assign if_l4.inst_mem_address = addr;  assign if_l4.inst_mem_flush = flush;

  logic        dv [N];
  logic        de [N];
  logic        dr [N];
  logic [31:0] dd [N];

  assign dv[0] = if_l1.inst_mem_is_valid;  assign dd[0] = if_l1.inst_mem_read_data;
  assign de[0] = if_l1.inst_mem_error;     assign dr[0] = if_l1.inst_mem_req_ready;
  assign dv[1] = if_l3.inst_mem_is_valid;  assign dd[1] = if_l3.inst_mem_read_data;
  assign de[1] = if_l3.inst_mem_error;     assign dr[1] = if_l3.inst_mem_req_ready;
  assign dv[2] = if_l4.inst_mem_is_valid;  assign dd[2] = if_l4.inst_mem_read_data;
  assign de[2] = if_l4.inst_mem_error;     assign dr[2] = if_l4.inst_mem_req_ready;

  inst_mem_responder #(.RESET(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .bus(if_l1), .init_we(init_we), .init_addr(init_addr), .init_data(init_data));
  inst_mem_responder #(.RESET(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .bus(if_l3), .init_we(init_we), .init_addr(init_addr), .init_data(init_data));
  inst_mem_responder #(.RESET(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .bus(if_l4), .init_we(init_we), .init_addr(init_addr), .init_data(init_data));

  // Reference model: expected responses per DUT, keyed by the edge after which they show.
  typedef struct { int due; logic [31:0] data; logic err; } exp_t;
  typedef struct { logic [31:0] data; logic err; } obs_t;

  exp_t        exp_q [N][$];
  obs_t        obs_q [N][$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] last_d [N];
  logic        last_e [N];
  logic [15:0] lfsr_m;
  int          edge_n = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 4;
  endfunction

  function automatic logic model_ready();
`ifdef INST_MEM_RANDOM_WAIT_EN
    return lfsr_m[1:0] != 2'b00;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    for (int d = 0; d < N; d++) begin
      exp_q[d].delete();
      last_d[d] = 32'h0;
      last_e[d] = 1'b0;
    end
    lfsr_m = 16'hACE1;
  endtask

  task automatic clear_obs();
    for (int d = 0; d < N; d++) obs_q[d].delete();
  endtask

  // One clock: drive inputs, advance the model across the edge, score every DUT.
  task automatic step(input logic r, input logic [31:0] a, input logic f, input logic w,
                      input logic [AW-1:0] wa, input logic [31:0] wd, output logic acc);
    logic rdy, bad, ev, ee;
    logic [31:0] off, rdat, ed;
    exp_t e;
    obs_t o;
    req = r; addr = a; flush = f; init_we = w; init_addr = wa; init_data = wd;
    rdy = model_ready();
    for (int d = 0; d < N; d++) begin
      checks++;
      if (dr[d] !== rdy) begin
        errors++;
        $display("FAIL ready l%0d edge %0d got %b want %b", lat_of(d), edge_n, dr[d], rdy);
      end
    end
    acc  = r && rdy;
    off  = a - BASE;
    bad  = (off >= 32'(DEPTH * 4)) || (a[1:0] != 2'b00);
    rdat = bad ? NOP_W : mem_m[off[AW+1:2]];
    @(posedge clk);
    #1;
    edge_n++;
    for (int d = 0; d < N; d++) begin
      if (f) exp_q[d].delete();
      if (acc) begin
        e.due = edge_n + lat_of(d) - 1; e.data = rdat; e.err = bad;
        exp_q[d].push_back(e);
      end
    end
    if (w) mem_m[wa] = wd;
    lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    for (int d = 0; d < N; d++) begin
      if (exp_q[d].size() > 0 && exp_q[d][0].due == edge_n) begin
        ev = 1'b1; ed = exp_q[d][0].data; ee = exp_q[d][0].err;
        void'(exp_q[d].pop_front());
        last_d[d] = ed; last_e[d] = ee;
      end else begin
        ev = 1'b0; ed = last_d[d]; ee = last_e[d];
      end
      if (dv[d] === 1'b1) begin
        o.data = dd[d]; o.err = de[d];
        obs_q[d].push_back(o);
      end
      checks += 3;
      if (dv[d] !== ev) begin
        errors++;
        $display("FAIL valid l%0d edge %0d got %b want %b", lat_of(d), edge_n, dv[d], ev);
      end
      if (dd[d] !== ed) begin
        errors++;
        $display("FAIL data l%0d edge %0d got %h want %h", lat_of(d), edge_n, dd[d], ed);
      end
      if (de[d] !== ee) begin
        errors++;
        $display("FAIL error l%0d edge %0d got %b want %b", lat_of(d), edge_n, de[d], ee);
      end
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    repeat (n) step(1'b0, 32'h0, 1'b0, 1'b0, '0, 32'h0, acc);
  endtask

  task automatic preload(input logic [AW-1:0] wa, input logic [31:0] wd);
    logic acc;
    step(1'b0, 32'h0, 1'b0, 1'b1, wa, wd, acc);
  endtask

  // Holds the request until accepted; the preload write only fires on the accepting edge.
  task automatic request(input logic [31:0] a, input logic f, input logic w,
                         input logic [AW-1:0] wa, input logic [31:0] wd);
    logic acc;
    int   tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 64) begin
      step(1'b1, a, f, w && model_ready(), wa, wd, acc);
      tries++;
    end
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout addr %h got no accept want accept", a);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 1'b0; flush = 1'b0; addr = 32'h0;
    init_we = 1'b0; init_addr = '0; init_data = 32'h0;
    #1;
    for (int d = 0; d < N; d++) begin
      checks += 4;
      if (dv[d] !== 1'b0)  begin errors++; $display("FAIL reset_valid l%0d got %b want 0", lat_of(d), dv[d]); end
      if (dd[d] !== 32'h0) begin errors++; $display("FAIL reset_data l%0d got %h want 0", lat_of(d), dd[d]); end
      if (de[d] !== 1'b0)  begin errors++; $display("FAIL reset_error l%0d got %b want 0", lat_of(d), de[d]); end
      if (dr[d] !== 1'b1)  begin errors++; $display("FAIL reset_ready l%0d got %b want 1", lat_of(d), dr[d]); end
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_preload_all();
    for (int i = 0; i < DEPTH; i++) preload(AW'(i), $urandom);
  endtask

  task automatic test_aligned();
    preload(AW'(5), 32'h0217_8793);
    request(32'h14, 1'b0, 1'b0, '0, 32'h0);
    checks++;
    if (dv[0] !== 1'b1 || dd[0] !== 32'h0217_8793 || de[0] !== 1'b0) begin
      errors++;
      $display("FAIL aligned_l1 got v=%b d=%h e=%b want v=1 d=02178793 e=0", dv[0], dd[0], de[0]);
    end
    idle(5);
  endtask

  task automatic test_stream();
    logic [31:0] want [3];
    want[0] = WORD_A; want[1] = WORD_B; want[2] = WORD_C;
    preload(AW'(0), WORD_A);
    preload(AW'(1), WORD_B);
    preload(AW'(2), WORD_C);
    clear_obs();
    request(32'h0, 1'b0, 1'b0, '0, 32'h0);
    request(32'h4, 1'b0, 1'b0, '0, 32'h0);
    request(32'h8, 1'b0, 1'b0, '0, 32'h0);
    idle(6);
    checks++;
    if (obs_q[1].size() != 3) begin
      errors++;
      $display("FAIL stream_count_l3 got %0d want 3", obs_q[1].size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_q[1][i].data !== want[i] || obs_q[1][i].err !== 1'b0) begin
          errors++;
          $display("FAIL stream_order_l3 slot %0d got %h/%b want %h/0", i, obs_q[1][i].data, obs_q[1][i].err, want[i]);
        end
      end
    end
  endtask

  task automatic test_illegal();
    clear_obs();
    request(32'h0000_0006, 1'b0, 1'b0, '0, 32'h0);
    request(32'(DEPTH * 4), 1'b0, 1'b0, '0, 32'h0);
    request(32'hFFFF_FFFC, 1'b0, 1'b0, '0, 32'h0);
    idle(6);
    for (int d = 0; d < N; d++) begin
      checks++;
      if (obs_q[d].size() != 3) begin
        errors++;
        $display("FAIL illegal_count l%0d got %0d want 3", lat_of(d), obs_q[d].size());
      end else begin
        for (int i = 0; i < 3; i++) begin
          checks++;
          if (obs_q[d][i].data !== NOP_W || obs_q[d][i].err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_resp l%0d slot %0d got %h/%b want 00000013/1", lat_of(d), i, obs_q[d][i].data, obs_q[d][i].err);
          end
        end
      end
    end
  endtask

  task automatic test_flush();
    clear_obs();
    request(32'h0, 1'b0, 1'b0, '0, 32'h0);
    request(32'h4, 1'b0, 1'b0, '0, 32'h0);
    request(32'h8, 1'b1, 1'b0, '0, 32'h0);
    idle(6);
`ifndef INST_MEM_RANDOM_WAIT_EN
    for (int d = 1; d < N; d++) begin
      checks++;
      if (obs_q[d].size() != 1 || obs_q[d][0].data !== WORD_C) begin
        errors++;
        $display("FAIL flush_survivor l%0d got %0d responses want 1 of %h", lat_of(d), obs_q[d].size(), WORD_C);
      end
    end
    checks++;
    if (obs_q[0].size() != 3) begin
      errors++;
      $display("FAIL flush_l1_count got %0d want 3", obs_q[0].size());
    end
`endif
  endtask

  task automatic test_preload_collision();
    logic [31:0] x, y;
    x = 32'hDEAD_0001;
    y = 32'hBEEF_0002;
    preload(AW'(2), x);
    clear_obs();
    request(32'h8, 1'b0, 1'b1, AW'(2), y);
    request(32'h8, 1'b0, 1'b0, '0, 32'h0);
    idle(5);
    for (int d = 0; d < N; d++) begin
      checks++;
      if (obs_q[d].size() != 2 || obs_q[d][0].data !== x || obs_q[d][1].data !== y) begin
        errors++;
        $display("FAIL collision l%0d got %0d responses first %h want %h then %h", lat_of(d), obs_q[d].size(),
                 (obs_q[d].size() > 0) ? obs_q[d][0].data : 32'h0, x, y);
      end
    end
  endtask

  task automatic test_reset_midflight();
    clear_obs();
    request(32'h0, 1'b0, 1'b0, '0, 32'h0);
    idle(1);
    reset = 1'b0; req = 1'b0; flush = 1'b0; init_we = 1'b0;
    #1;
    for (int d = 0; d < N; d++) begin
      checks++;
      if (dv[d] !== 1'b0) begin errors++; $display("FAIL midreset_valid l%0d got %b want 0", lat_of(d), dv[d]); end
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    for (int d = 0; d < N; d++) begin
      checks++;
      if (dr[d] !== 1'b1) begin errors++; $display("FAIL midreset_ready l%0d got %b want 1", lat_of(d), dr[d]); end
    end
    idle(6);
    for (int d = 1; d < N; d++) begin
      checks++;
      if (obs_q[d].size() != 0) begin
        errors++;
        $display("FAIL midreset_lost l%0d got %0d responses want 0", lat_of(d), obs_q[d].size());
      end
    end
  endtask

  task automatic test_held();
    clear_obs();
    for (int i = 0; i < 20; i++) request(32'($urandom_range(DEPTH - 1)) << 2, 1'b0, 1'b0, '0, 32'h0);
    idle(6);
    for (int d = 0; d < N; d++) begin
      checks++;
      if (obs_q[d].size() != 20) begin
        errors++;
        $display("FAIL held_count l%0d got %0d want 20", lat_of(d), obs_q[d].size());
      end
    end
  endtask

  task automatic test_random();
    logic        pend, acc, f, w;
    logic [31:0] pa;
    int          sel;
    pend = 1'b0;
    pa = 32'h0;
    for (int c = 0; c < 300; c++) begin
      if (!pend && $urandom_range(9) < 7) begin
        pend = 1'b1;
        sel  = $urandom_range(9);
        if (sel < 8)       pa = 32'($urandom_range(DEPTH - 1)) << 2;
        else if (sel == 8) pa = (32'($urandom_range(DEPTH - 1)) << 2) | 32'($urandom_range(3, 1));
        else               pa = 32'(DEPTH * 4) + (32'($urandom_range(1023)) << 2);
      end
      f = ($urandom_range(99) < 8);
      w = ($urandom_range(4) == 0);
      step(pend, pa, f, w, AW'($urandom_range(DEPTH - 1)), $urandom, acc);
      if (acc) pend = 1'b0;
    end
    idle(6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_preload_all();
    test_aligned();
    test_stream();
    test_illegal();
    test_flush();
    test_preload_collision();
    test_reset_midflight();
    test_held();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Instruction-memory responder: the memory end of the fetch interface whose consumer is the fetch/decode stage.
- Accepts word fetch requests from the core's PC logic and returns `inst_mem_is_valid` / `inst_mem_read_data` after a fixed pipelined latency.
- Holds a synchronous-read word array, preloadable through a side write port.
- Flags misaligned and out-of-range fetches; supports flush for redirects.

Parameters:
- RESET, 32'h0000_0000, byte base address of word 0 of the array.
- DEPTH_WORDS, 4096, number of 32-bit words (power of 2, ≥ 16).
- LATENCY, 1, cycles from request acceptance edge to response valid; legal 1..4.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- inst_mem_req  in  1  fetch request strobe.
- inst_mem_address  in  32  byte address of fetch.
- inst_mem_req_ready  out  1  request accepted this cycle when high with `inst_mem_req`.
- inst_mem_flush  in  1  discard all in-flight responses.
- inst_mem_is_valid  out  1  response valid, one cycle per response.
- inst_mem_read_data  out  32  instruction word.
- inst_mem_error  out  1  response is for a misaligned or out-of-range address; qualified by valid.
- init_we  in  1  preload write enable.
- init_addr  in  log2(DEPTH_WORDS)  preload word index.
- init_data  in  32  preload word.

Behaviour:
- Reset (async, reset==0):
  - `inst_mem_is_valid` = 0, `inst_mem_read_data` = 32'h0, `inst_mem_error` = 0, `inst_mem_req_ready` = 1.
  - All pipeline valid bits cleared.
  - Array contents not reset.
- Accept: request is accepted on an edge where `inst_mem_req` && `inst_mem_req_ready`.
  - Without the optional feature, `inst_mem_req_ready` is constant 1 out of reset.
  - No backpressure from the consumer: responses are never held.
- Index: idx = (address − RESET) >> 2.
  - In range iff (address − RESET) < DEPTH_WORDS*4, compared as unsigned 32-bit; the subtraction wraps mod 2^32, so addresses below RESET are out of range.
  - Misaligned iff address[1:0] != 0.
- Response content:
  - Legal request: data = mem[idx], error = 0.
  - Out-of-range or misaligned: data = NOP (32'h0000_0013), error = 1; the array is not read.
- Latency: pipeline of LATENCY stages, each holding {valid, data, error}.
  - Array read occurs at the acceptance edge into stage 1.
  - Request accepted at edge k produces valid=1 in the cycle following edge k+LATENCY−1. With LATENCY=1, data appears in the cycle right after acceptance.
  - One response per accepted request, in order; throughput 1 per cycle.
- `inst_mem_is_valid` is low in any cycle with no response due. `inst_mem_read_data` and `inst_mem_error` hold their last values when valid=0.
- Flush:
  - On an edge with `inst_mem_flush`=1, all stage valid bits clear, including the one that would drive the output next cycle.
  - A request accepted on the same edge as a flush is kept and is the first response after the flush.
- Preload:
  - `init_we` writes mem[init_addr] at the edge.
  - A fetch of the same word on the same edge returns the old contents (read-before-write). The new value is visible to requests accepted on later edges.
  - Preload and fetch are permitted in the same cycle.
- Reset asserted mid-operation: in-flight responses are lost, no valid is produced for them, and the block resumes accepting on the first edge after release.

Optional Feature:
- Macro: INST_MEM_RANDOM_WAIT_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1 on reset) advances every cycle.
  - `inst_mem_req_ready` = 0 in cycles where lfsr[1:0]==2'b00 (~25% wait states).
  - Unaccepted requests must be held by the initiator.
  - Latency after acceptance is unchanged.
- Undefined: `inst_mem_req_ready` is tied to 1 and no LFSR logic exists.

Decomposition:
- Shared package (or the existing opcode include):
  - NOP constant 32'h0000_0013.
  - LFSR seed and taps constants.
- Sub-module inst_mem_resp_pipe: a parameterised LATENCY-stage {valid, data, error} delay line with flush. The array and address checks stay in the top.

Test Plan:
- Aligned fetch: LATENCY=1, RESET=0, preload mem[5]=32'h02178793, request addr 32'h14 → next cycle valid=1, data=32'h02178793, error=0.
- Streaming throughput: LATENCY=3, back-to-back requests to 0x0, 0x4, 0x8 with preloaded words A, B, C → valid on 3 consecutive cycles starting 3 cycles after the first accept, in order A, B, C.
- Illegal addresses:
  - Request addr 32'h6 → data=32'h00000013, error=1.
  - Request addr DEPTH_WORDS*4 → data=32'h00000013, error=1.
- Flush with same-edge request: LATENCY=3, requests at 0x0 and 0x4, flush on the same edge as a request to 0x8 → only the 0x8 response appears; no valid for 0x0 or 0x4.
- Preload collision: mem[2]=X, then init_we mem[2]=Y on the same edge as a fetch of 0x8 → X returned; a fetch of 0x8 next cycle → Y.
- Reset mid-flight: LATENCY=4, reset asserted 2 cycles after a request → valid stays 0 and ready=1 after release. With INST_MEM_RANDOM_WAIT_EN, hold a request until ready → exactly one response per held request.
